inv_fermat_2161: RTL
====================

# inv_fermat_2161

Sequential modular-inverse unit for the prime modulus q = 2161. It accepts a 12-bit residue a and returns a^(q-2) = a^2159 mod 2161, which is a^-1 mod q. It computes this by left-to-right square-and-multiply, doing one modular multiply per cycle with an internal Barrett-style reducer. It sits upstream of the mod-2161 reduction datapath and supplies inverted operands (division, normalisation). It uses valid/ready handshakes on both sides.

## Interface
- Q, 2161: modulus. Fixed prime; the constants below are derived for it.
- EXP, 12'b1000_0110_1111: exponent q-2 = 2159. Bit 11 is always 1.
- MU, 7763: Barrett constant, floor(2^24/2161).
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand valid.
- in_ready  output  1  unit can accept an operand.
- din_a  input  12  operand a.
- out_valid  output  1  result valid, held until taken.
- out_ready  input  1  downstream accepts the result.
- dout_r  output  12  a^-1 mod 2161, in the range 0..2160.
- dout_err  output  1  operand had no inverse: a == 0 or a >= 2161.

## Operation
- FSM states are IDLE, SQR, MUL, DONE.
- Reset values:
  - state = IDLE, acc = 0, idx = 0, a_reg = 0.
  - in_ready = 1, out_valid = 0, dout_r = 0, dout_err = 0.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: a_reg <= din_a, acc <= din_a, idx <= 10, err_reg <= (din_a == 0 || din_a >= 2161).
  - Then go to SQR.
- SQR:
  - acc <= modmul(acc, acc).
  - If EXP[idx] == 1, go to MUL.
  - Else if idx == 0, go to DONE.
  - Else idx <= idx - 1 and stay in SQR.
- MUL:
  - acc <= modmul(acc, a_reg).
  - If idx == 0, go to DONE.
  - Else idx <= idx - 1 and go to SQR.
- DONE:
  - out_valid = 1.
  - dout_r = err_reg ? 0 : acc, and dout_err = err_reg.
  - On out_ready, go to IDLE.
  - dout_r and dout_err stay stable while out_valid is high and out_ready is low.
- modmul(x, y): exact residue of x*y mod 2161.
  - Product p is 23 bits wide; the maximum product is 2160^2 = 4,665,600.
  - t = ((p >> 12) * MU) >> 12, computed with an intermediate of at least 24 bits. No truncation is allowed.
  - r = p - t*2161, followed by up to two conditional subtractions of 2161.
  - The reducer is combinational within one cycle and its output is registered into acc.
- Erroneous operands run the full sequence, so latency is data-independent. Only the output is forced.
- in_ready = 0 in every state except IDLE. A new operand is not accepted in the cycle that DONE hands off; it is accepted at the earliest on the next cycle, in IDLE.
- Asserting rst_n low mid-operation aborts immediately. All state returns to reset values and no partial result is emitted.

## Timing
- Exponent bits 10..0 need 11 squares and 6 multiplies, so there are 17 compute cycles.
- The acceptance edge is edge 0. out_valid is high after edge 17 and stays high until the edge where out_ready is sampled high.
- Throughput: one result per 19 cycles with out_ready tied high (accept, 17 compute, 1 DONE).
- Outputs are driven from registers only. There is no combinational path from din_a or in_valid to any output.
- in_ready is decoded from state only. It does not depend on out_ready.

## Test plan
- a = 1 -> dout_r = 1, dout_err = 0, with out_valid exactly 17 edges after acceptance.
- a = 2 -> 1081. a = 3 -> 1441. a = 2160 -> 2160. All with dout_err = 0.
- a = 0 -> dout_r = 0, dout_err = 1. a = 2161 and a = 4095 -> dout_r = 0, dout_err = 1. Latency is unchanged in all error cases.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises. out_valid, dout_r and dout_err must stay stable, and in_ready must stay 0. Release, then return to IDLE on the next edge.
- Reset mid-operation: pulse rst_n low 5 cycles after accepting a = 5, then run a = 7. All outputs are at reset values during reset, no stale result appears, and the result is 1235 (7*1235 = 8645 = 4*2161 + 1).
- Exhaustive sweep of a = 1..2160 with random out_ready stalls. Every result satisfies (a * dout_r) mod 2161 == 1, and every modmul product matches a reference mod model.

Source files
------------

// File: rtl/inv_fermat_2161.sv
// Modular inverse a^-1 mod 2161 via Fermat's little theorem (a^2159).
// Left-to-right square-and-multiply, one Barrett-reduced multiply per cycle.
module inv_fermat_2161 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] din_a,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] dout_r,
   output logic        dout_err
);

   localparam logic [11:0] Q   = 12'd2161;
   localparam logic [11:0] EXP = 12'b1000_0110_1111;
   localparam logic [12:0] MU  = 13'd7763;
   localparam logic [25:0] QW  = 26'd2161;

   typedef enum logic [1:0] {
      IDLE,
      SQR,
      MUL,
      DONE
   } state_t;

   state_t      state;
   logic [11:0] acc;
   logic [11:0] a_reg;
   logic [3:0]  idx;
   logic        err_reg;

   logic [11:0] mm_y;
   logic [23:0] prod;
   logic [11:0] p_hi;
   logic [24:0] est;
   logic [12:0] t;
   logic [25:0] tq;
   logic [25:0] r0;
   logic [25:0] r1;
   logic [11:0] mm;

   // Barrett: t never exceeds the true quotient, so r0 cannot wrap.
   assign mm_y = (state == MUL) ? a_reg : acc;
   assign prod = {12'd0, acc} * {12'd0, mm_y};
   assign p_hi = 12'(prod >> 12);
   assign est  = {13'd0, p_hi} * {12'd0, MU};
   assign t    = 13'(est >> 12);
   assign tq   = {13'd0, t} * {13'd0, Q, 1'b0} >> 1;
   assign r0   = {2'd0, prod} - tq;
   assign r1   = (r0 >= QW) ? r0 - QW : r0;
   assign mm   = 12'((r1 >= QW) ? r1 - QW : r1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= 12'd0;
         a_reg     <= 12'd0;
         idx       <= 4'd0;
         err_reg   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         dout_r    <= 12'd0;
         dout_err  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg    <= din_a;
                  acc      <= din_a;
                  idx      <= 4'd10;
                  err_reg  <= (din_a == 12'd0) || (din_a >= Q);
                  in_ready <= 1'b0;
                  state    <= SQR;
               end
            end
            SQR: begin
               acc <= mm;
               if (EXP[idx]) begin
                  state <= MUL;
               end else if (idx == 4'd0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  dout_r    <= err_reg ? 12'd0 : mm;
                  dout_err  <= err_reg;
               end else begin
                  idx <= idx - 4'd1;
               end
            end
            MUL: begin
               acc <= mm;
               if (idx == 4'd0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  dout_r    <= err_reg ? 12'd0 : mm;
                  dout_err  <= err_reg;
               end else begin
                  idx   <= idx - 4'd1;
                  state <= SQR;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
